// File: rtl/counter_pkg.sv
// Shared types for the multi-channel modulo counter.
package counter_pkg;

    // What a channel does once it reaches its terminal count
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_e;

    localparam int MODE_W = 2;

endpackage

// File: rtl/counter_channel.sv
// One programmable up/down modulo counter with wrap, saturate or one-shot
// terminal behaviour. step_tc is combinational so a neighbour can chain on it.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  cmax,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc,
    output logic              done,
    output logic              step_tc
);

    cnt_mode_e        m;
    logic             at_term;
    logic             frozen;
    logic             adv;
    logic [WIDTH-1:0] cnt_nxt;
    logic             done_nxt;

    // Encoding 3 is not named in the enum and falls into the wrap branch
    assign m       = cnt_mode_e'(mode);
    // Up counts treat any value at or above the limit as terminal, so a
    // limit lowered under the running count still terminates
    assign at_term = up ? (cnt >= cmax) : (cnt == '0);
    // A finished one-shot ignores enables until reloaded
    assign frozen  = (m == CNT_ONESHOT) && done;
    assign adv     = en && !frozen;
    assign step_tc = adv && at_term;

    // Next count/done for an enabled step
    always_comb begin
        cnt_nxt  = cnt;
        done_nxt = done;
        if (adv) begin
            if (at_term) begin
                case (m)
                    CNT_SAT: begin
                        if (up && (cnt > cmax)) cnt_nxt = cmax;
                    end
                    CNT_ONESHOT: done_nxt = 1'b1;
                    default: cnt_nxt = up ? '0 : cmax;
                endcase
            end else begin
                cnt_nxt = up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
            end
        end
    end

    // State register: reset beats load beats counting
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tc   <= step_tc;
            done <= done_nxt;
        end
    end

endmodule

// File: rtl/counter_array.sv
// NCH independent counter channels; with CASCADE set each channel after the
// first only advances on its predecessor's terminal step (same-cycle ripple).
module counter_array
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter bit CASCADE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ce,
    input  logic [NCH-1:0]        up,
    input  logic [NCH-1:0]        load,
    input  logic [NCH*WIDTH-1:0]  load_val,
    input  logic [NCH*WIDTH-1:0]  cmax,
    input  logic [MODE_W*NCH-1:0] mode,
    output logic [NCH*WIDTH-1:0]  cnt,
    output logic [NCH-1:0]        tc,
    output logic [NCH-1:0]        done
);

    // Collected carries; the last stage's carry has no consumer
    logic [NCH-1:0] stp_all;
    logic           unused_stp;

    assign unused_stp = &{1'b0, stp_all};

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            // Per-stage scalars keep the ripple chain free of vector self-loops
            logic en_i;
            logic stp_i;

            if (CASCADE && (i > 0)) begin : g_casc
                assign en_i = ce[i] & g_ch[i-1].stp_i;
            end else begin : g_direct
                assign en_i = ce[i];
            end

            assign stp_all[i] = stp_i;

            counter_channel #(.WIDTH(WIDTH)) u_ch (
                .clk      (clk),
                .rst      (rst),
                .en       (en_i),
                .up       (up[i]),
                .load     (load[i]),
                .load_val (load_val[i*WIDTH +: WIDTH]),
                .cmax     (cmax[i*WIDTH +: WIDTH]),
                .mode     (mode[i*MODE_W +: MODE_W]),
                .cnt      (cnt[i*WIDTH +: WIDTH]),
                .tc       (tc[i]),
                .done     (done[i]),
                .step_tc  (stp_i)
            );
        end
    endgenerate

endmodule

// File: tb/tb_counter_array.sv
// Bench for counter_array: an independent 4-channel instance and a 2-channel
// cascaded instance, checked against a per-cycle reference model.
module tb_counter_array;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ce   [2];
    logic [3:0]  up   [2];
    logic [3:0]  load [2];
    logic [31:0] lv   [2];
    logic [31:0] cm   [2];
    logic [7:0]  md   [2];

    logic [31:0] cnt_a;
    logic [3:0]  tc_a, done_a;
    logic [15:0] cnt_b;
    logic [1:0]  tc_b, done_b;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference state: [dut][channel]
    int m_cnt  [2][4];
    bit m_tc   [2][4];
    bit m_done [2][4];

    always #5 clk = ~clk;

    counter_array #(.WIDTH(8), .NCH(4), .CASCADE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .ce(ce[0]), .up(up[0]), .load(load[0]),
        .load_val(lv[0]), .cmax(cm[0]), .mode(md[0]),
        .cnt(cnt_a), .tc(tc_a), .done(done_a)
    );

    counter_array #(.WIDTH(8), .NCH(2), .CASCADE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .ce(ce[1][1:0]), .up(up[1][1:0]), .load(load[1][1:0]),
        .load_val(lv[1][15:0]), .cmax(cm[1][15:0]), .mode(md[1][3:0]),
        .cnt(cnt_b), .tc(tc_b), .done(done_b)
    );

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic [7:0] get_cnt(input int d, input int i);
        return (d == 0) ? cnt_a[i*8 +: 8] : cnt_b[i*8 +: 8];
    endfunction

    function automatic logic get_tc(input int d, input int i);
        return (d == 0) ? tc_a[i] : tc_b[i];
    endfunction

    function automatic logic get_done(input int d, input int i);
        return (d == 0) ? done_a[i] : done_b[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance the reference by one edge using the inputs currently applied
    task automatic model_step();
        int c, lim, mo;
        bit u, en, term, stp, prev, hold;
        for (int d = 0; d < 2; d++) begin
            prev = 1'b0;
            for (int i = 0; i < nch(d); i++) begin
                c    = m_cnt[d][i];
                lim  = int'(cm[d][i*8 +: 8]);
                mo   = int'(md[d][2*i +: 2]);
                u    = up[d][i];
                en   = ce[d][i] && (d == 0 || i == 0 || prev);
                term = u ? (c >= lim) : (c == 0);
                hold = (mo == 2) && m_done[d][i];
                stp  = en && term && !hold;
                prev = stp;
                if (rst) begin
                    m_cnt[d][i] = 0; m_tc[d][i] = 0; m_done[d][i] = 0;
                end else if (load[d][i]) begin
                    m_cnt[d][i] = int'(lv[d][i*8 +: 8]); m_tc[d][i] = 0; m_done[d][i] = 0;
                end else begin
                    m_tc[d][i] = stp;
                    if (en && !hold) begin
                        if (!term)      m_cnt[d][i] = u ? (c + 1) % 256 : (c + 255) % 256;
                        else if (mo == 1) m_cnt[d][i] = (u && c > lim) ? lim : c;
                        else if (mo == 2) m_done[d][i] = 1;
                        else            m_cnt[d][i] = u ? 0 : lim;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < nch(d); i++) begin
                chk($sformatf("d%0d_cnt%0d", d, i), 32'(get_cnt(d, i)), m_cnt[d][i]);
                chk($sformatf("d%0d_tc%0d", d, i), 32'(get_tc(d, i)), 32'(m_tc[d][i]));
                chk($sformatf("d%0d_done%0d", d, i), 32'(get_done(d, i)), 32'(m_done[d][i]));
            end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr_inputs();
        for (int d = 0; d < 2; d++) begin
            ce[d] = '0; up[d] = '0; load[d] = '0; lv[d] = '0; cm[d] = '0; md[d] = '0;
        end
    endtask

    int s1 [6] = '{1, 2, 0, 1, 2, 0};
    int t1 [6] = '{0, 0, 1, 0, 0, 1};
    int s2 [3] = '{0, 5, 4};
    int t2 [3] = '{0, 1, 0};
    int s3 [6] = '{1, 2, 3, 3, 3, 3};
    int t3 [6] = '{0, 0, 0, 1, 0, 0};
    int d3 [6] = '{0, 0, 0, 1, 1, 1};
    int pulses0, pulses1;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                m_cnt[d][i] = 0; m_tc[d][i] = 0; m_done[d][i] = 0;
            end
        clr_inputs();

        // Reset state
        rst = 1'b1;
        step();
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_tc_a", 32'(tc_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_cnt_b", 32'(cnt_b), 0);
        rst = 1'b0;

        // ch0 up/wrap, limit 2
        cm[0][7:0] = 8'd2; up[0][0] = 1'b1; ce[0][0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("wrap_up_cnt", 32'(cnt_a[7:0]), s1[k]);
            chk("wrap_up_tc", 32'(tc_a[0]), t1[k]);
        end
        ce[0] = '0;

        // ch1 down/wrap, limit 5, loaded with 1
        cm[0][15:8] = 8'd5; up[0][1] = 1'b0; lv[0][15:8] = 8'd1; load[0][1] = 1'b1;
        step();
        chk("down_load_cnt", 32'(cnt_a[15:8]), 1);
        load[0] = '0; ce[0][1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wrap_dn_cnt", 32'(cnt_a[15:8]), s2[k]);
            chk("wrap_dn_tc", 32'(tc_a[1]), t2[k]);
        end
        ce[0] = '0;

        // ch2 one-shot up, limit 3
        cm[0][23:16] = 8'd3; md[0][5:4] = 2'd2; up[0][2] = 1'b1; lv[0][23:16] = 8'd0;
        load[0][2] = 1'b1;
        step();
        load[0] = '0; ce[0][2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("oneshot_cnt", 32'(cnt_a[23:16]), s3[k]);
            chk("oneshot_tc", 32'(tc_a[2]), t3[k]);
            chk("oneshot_done", 32'(done_a[2]), d3[k]);
        end
        load[0][2] = 1'b1;
        step();
        chk("oneshot_reload_done", 32'(done_a[2]), 0);
        chk("oneshot_reload_cnt", 32'(cnt_a[23:16]), 0);
        load[0] = '0;
        step();
        chk("oneshot_resume_cnt", 32'(cnt_a[23:16]), 1);
        ce[0] = '0;

        // Cascaded decimal pair
        cm[1][15:0] = {8'd9, 8'd9}; up[1] = 4'b0011; load[1] = 4'b0011;
        step();
        load[1] = '0; ce[1] = 4'b0011;
        pulses0 = 0; pulses1 = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (tc_b[0]) pulses0++;
            if (tc_b[1]) pulses1++;
            if (k == 57) chk("casc_57", 32'(cnt_b), 32'h0507);
            if (k == 99) chk("casc_99", 32'(cnt_b), 32'h0909);
        end
        chk("casc_final_cnt", 32'(cnt_b), 0);
        chk("casc_last_tc1", 32'(tc_b[1]), 1);
        chk("casc_tc1_pulses", pulses1, 1);
        chk("casc_tc0_pulses", pulses0, 10);
        ce[1] = '0;

        // ch3 saturate up: limit lowered under the running count
        md[0][7:6] = 2'd1; up[0][3] = 1'b1; cm[0][31:24] = 8'd10; lv[0][31:24] = 8'd7;
        load[0][3] = 1'b1;
        step();
        load[0] = '0; cm[0][31:24] = 8'd4; ce[0][3] = 1'b1;
        step();
        chk("sat_force_cnt", 32'(cnt_a[31:24]), 4);
        chk("sat_force_tc", 32'(tc_a[3]), 1);
        step();
        chk("sat_hold_cnt", 32'(cnt_a[31:24]), 4);
        chk("sat_hold_tc", 32'(tc_a[3]), 1);

        // Reset wins over load and enable
        rst = 1'b1; load[0] = 4'hf; load[1] = 4'h3; ce[0] = 4'hf; ce[1] = 4'h3;
        lv[0] = 32'h12345678; lv[1] = 32'h0000abcd;
        step();
        chk("rst_prio_cnt_a", cnt_a, 0);
        chk("rst_prio_tc_a", 32'(tc_a), 0);
        chk("rst_prio_done_a", 32'(done_a), 0);
        chk("rst_prio_cnt_b", 32'(cnt_b), 0);
        rst = 1'b0;
        clr_inputs();

        // Randomized traffic on both instances
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int d = 0; d < 2; d++) begin
                ce[d] = (d == 1) ? (($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hf)
                                 : 4'($urandom());
                if ($urandom_range(0, 9) == 0) up[d] = 4'($urandom());
                load[d] = ($urandom_range(0, 11) == 0) ? 4'($urandom()) : 4'h0;
                for (int i = 0; i < 4; i++) begin
                    lv[d][i*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom())
                                                                  : 8'($urandom_range(0, 15));
                    if ($urandom_range(0, 19) == 0)
                        cm[d][i*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'hff
                                                                      : 8'($urandom_range(0, 12));
                    if ($urandom_range(0, 29) == 0) md[d][2*i +: 2] = 2'($urandom());
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
